// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side outputs of the ID/EX pipeline register.
// The master modport drives the decoded instruction; the slave modport is the stage itself.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CNT_W = 16
);
    logic [13:0]    id_ctrl;
    logic           id_regdst;
    logic           id_uses_rt;
    logic [DW-1:0]  id_pc4;
    logic [DW-1:0]  id_rs_data;
    logic [DW-1:0]  id_rt_data;
    logic [DW-1:0]  id_imm;
    logic [AW-1:0]  id_rs;
    logic [AW-1:0]  id_rt;
    logic [AW-1:0]  id_rd;
    logic [4:0]     id_shamt;
    logic           hold;
    logic           flush;
    logic           stall;
    logic [13:0]    ex_ctrl;
    logic [DW-1:0]  ex_pc4;
    logic [DW-1:0]  ex_rs_data;
    logic [DW-1:0]  ex_rt_data;
    logic [DW-1:0]  ex_imm;
    logic [AW-1:0]  ex_rs;
    logic [AW-1:0]  ex_rt;
    logic [AW-1:0]  ex_wreg;
    logic [4:0]     ex_shamt;
    logic [CNT_W-1:0] bubble_cnt;
    modport master (
        output id_ctrl, id_regdst, id_uses_rt, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_shamt, hold, flush,
        input  stall, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
               ex_wreg, ex_shamt, bubble_cnt
    );
    modport slave (
        input  id_ctrl, id_regdst, id_uses_rt, id_pc4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_shamt, hold, flush,
        output stall, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
               ex_wreg, ex_shamt, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with flush/load-use bubble insertion and a saturating bubble counter.
// Load-use hazard detection is present only when ID_EX_LOADUSE_EN is defined.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    id_ex_stage_if.slave bus
);
    logic hz;
    logic kill;
`ifdef ID_EX_LOADUSE_EN
    // A load in EX cannot forward its result in time to the instruction now in ID
    assign hz = bus.ex_ctrl[10] && (bus.ex_rt != AW'(0)) &&
                ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
`else
    assign hz = 1'b0;
`endif
    assign bus.stall = hz | bus.hold;
    assign kill = !rst_n || bus.flush || hz;
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.hold) begin
            bus.ex_ctrl    <= kill ? 14'd0 : bus.id_ctrl;
            bus.ex_pc4     <= kill ? DW'(0) : bus.id_pc4;
            bus.ex_rs_data <= kill ? DW'(0) : bus.id_rs_data;
            bus.ex_rt_data <= kill ? DW'(0) : bus.id_rt_data;
            bus.ex_imm     <= kill ? DW'(0) : bus.id_imm;
            bus.ex_rs      <= kill ? AW'(0) : bus.id_rs;
            bus.ex_rt      <= kill ? AW'(0) : bus.id_rt;
            bus.ex_wreg    <= kill ? AW'(0) : (bus.id_regdst ? bus.id_rt : bus.id_rd);
            bus.ex_shamt   <= kill ? 5'd0 : bus.id_shamt;
        end
        if (!rst_n)
            bus.bubble_cnt <= CNT_W'(0);
        else if (!bus.hold && (bus.flush || hz) && !(&bus.bubble_cnt))
            bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed MIPS sequences plus random stimulus checked against a behavioural model.
// Works with ID_EX_LOADUSE_EN defined or undefined; the counter is built 4 bits wide to reach saturation.
module tb_id_ex_stage;
    localparam int DW = 32, AW = 5, CNT_W = 4, CMAX = 15;
`ifdef ID_EX_LOADUSE_EN
    localparam int LU = 1;
`else
    localparam int LU = 0;
`endif
    typedef struct packed {
        logic [13:0] ctrl;
        logic [31:0] pc4, rsd, rtd, imm;
        logic [4:0]  rs, rt, wreg, shamt;
    } ex_t;

    logic clk = 0;
    logic rst_n = 0;
    int n_cmp = 0, n_bad = 0, lc = 0;
    ex_t m;
    int m_cnt = 0;
    bit mvalid = 0;

    id_ex_stage_if #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) bus();
    id_ex_stage #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Load in EX writing a nonzero register that the ID instruction reads
    function automatic bit exp_hz();
        if (LU == 0) return 1'b0;
        if (!m.ctrl[10] || m.rt == 5'd0) return 1'b0;
        return (m.rt == bus.id_rs) || (bus.id_uses_rt && m.rt == bus.id_rt);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m <= '0;
            m_cnt <= 0;
            mvalid <= 1;
        end else if (!bus.hold) begin
            if (bus.flush || exp_hz()) begin
                m <= '0;
                m_cnt <= (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
            end else begin
                m <= '{ctrl: bus.id_ctrl, pc4: bus.id_pc4, rsd: bus.id_rs_data, rtd: bus.id_rt_data,
                       imm: bus.id_imm, rs: bus.id_rs, rt: bus.id_rt,
                       wreg: bus.id_regdst ? bus.id_rt : bus.id_rd, shamt: bus.id_shamt};
            end
        end
    end

    always begin
        @(posedge clk);
        #4;
        if (mvalid) begin
            chk("m_ctrl", 64'(bus.ex_ctrl), 64'(m.ctrl));
            chk("m_pc4", 64'(bus.ex_pc4), 64'(m.pc4));
            chk("m_rs_data", 64'(bus.ex_rs_data), 64'(m.rsd));
            chk("m_rt_data", 64'(bus.ex_rt_data), 64'(m.rtd));
            chk("m_imm", 64'(bus.ex_imm), 64'(m.imm));
            chk("m_rs", 64'(bus.ex_rs), 64'(m.rs));
            chk("m_rt", 64'(bus.ex_rt), 64'(m.rt));
            chk("m_wreg", 64'(bus.ex_wreg), 64'(m.wreg));
            chk("m_shamt", 64'(bus.ex_shamt), 64'(m.shamt));
            chk("m_cnt", 64'(bus.bubble_cnt), 64'(m_cnt));
            chk("m_stall", 64'(bus.stall), 64'(exp_hz() | bus.hold));
        end
    end

    task automatic set_id(logic [13:0] c, logic rsel, logic ur, logic [4:0] rs, logic [4:0] rt,
                          logic [4:0] rd, logic [31:0] imm);
        bus.id_ctrl = c;
        bus.id_regdst = rsel;
        bus.id_uses_rt = ur;
        bus.id_rs = rs;
        bus.id_rt = rt;
        bus.id_rd = rd;
        bus.id_imm = imm;
        bus.id_pc4 = $urandom;
        bus.id_rs_data = $urandom;
        bus.id_rt_data = $urandom;
        bus.id_shamt = 5'($urandom);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.hold = 0;
        bus.flush = 0;
        set_id(14'h3FFF, 1, 1, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF);
        tick();
        tick();
        chk("rst_ctrl", 64'(bus.ex_ctrl), 64'd0);
        chk("rst_wreg", 64'(bus.ex_wreg), 64'd0);
        chk("rst_imm", 64'(bus.ex_imm), 64'd0);
        chk("rst_pc4", 64'(bus.ex_pc4), 64'd0);
        chk("rst_cnt", 64'(bus.bubble_cnt), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        rst_n = 1;
        // ORI $8,$0,0x1234
        set_id(14'h00C5, 1, 0, 5'd0, 5'd8, 5'd0, 32'h0000_1234);
        tick();
        chk("ori_wreg", 64'(bus.ex_wreg), 64'd8);
        chk("ori_imm", 64'(bus.ex_imm), 64'h1234);
        chk("ori_ctrl", 64'(bus.ex_ctrl), 64'h00C5);
        // LW $9,0($4) ; ADDU $10,$9,$2
        set_id(14'h06C0, 1, 0, 5'd4, 5'd9, 5'd0, 32'd0);
        tick();
        chk("lw_wreg", 64'(bus.ex_wreg), 64'd9);
        set_id(14'h0080, 0, 1, 5'd9, 5'd2, 5'd10, 32'd0);
        #2 chk("lu_stall", 64'(bus.stall), 64'(LU));
        tick();
        chk("lu_bubble", 64'(bus.ex_ctrl), LU ? 64'd0 : 64'h0080);
        chk("lu_cnt", 64'(bus.bubble_cnt), 64'(LU));
        #2 chk("lu_stall_gone", 64'(bus.stall), 64'd0);
        tick();
        chk("addu_wreg", 64'(bus.ex_wreg), 64'd10);
        chk("addu_ctrl", 64'(bus.ex_ctrl), 64'h0080);
        lc = LU;
        // LW $0 never causes a hazard
        set_id(14'h06C0, 1, 0, 5'd4, 5'd0, 5'd0, 32'd0);
        tick();
        set_id(14'h0080, 0, 1, 5'd0, 5'd2, 5'd10, 32'd0);
        #2 chk("lw0_stall", 64'(bus.stall), 64'd0);
        tick();
        // LW $5 ; SW $5,0($3) depends through rt
        set_id(14'h06C0, 1, 0, 5'd3, 5'd5, 5'd0, 32'd4);
        tick();
        set_id(14'h0140, 1, 1, 5'd3, 5'd5, 5'd0, 32'd0);
        #2 chk("sw_stall", 64'(bus.stall), 64'(LU));
        tick();
        chk("sw_bubble", 64'(bus.ex_ctrl), LU ? 64'd0 : 64'h0140);
        tick();
        chk("sw_ctrl", 64'(bus.ex_ctrl), 64'h0140);
        lc += LU;
        chk("sw_cnt", 64'(bus.bubble_cnt), 64'(lc));
        set_id(14'h06C0, 1, 0, 5'd3, 5'd5, 5'd0, 32'd4);
        tick();
        set_id(14'h0140, 1, 0, 5'd3, 5'd5, 5'd0, 32'd0);
        #2 chk("sw_nort_stall", 64'(bus.stall), 64'd0);
        tick();
        chk("sw_nort_ctrl", 64'(bus.ex_ctrl), 64'h0140);
        // hold beats flush
        bus.hold = 1;
        bus.flush = 1;
        for (int i = 0; i < 3; i++) begin
            #2 chk("hold_stall", 64'(bus.stall), 64'd1);
            tick();
            chk("hold_ctrl", 64'(bus.ex_ctrl), 64'h0140);
            chk("hold_cnt", 64'(bus.bubble_cnt), 64'(lc));
        end
        bus.hold = 0;
        tick();
        lc++;
        chk("flush_ctrl", 64'(bus.ex_ctrl), 64'd0);
        chk("flush_cnt", 64'(bus.bubble_cnt), 64'(lc));
        // flush and load-use together count once
        bus.flush = 0;
        set_id(14'h06C0, 1, 0, 5'd3, 5'd6, 5'd0, 32'd0);
        tick();
        bus.flush = 1;
        set_id(14'h0080, 0, 1, 5'd6, 5'd2, 5'd10, 32'd0);
        #2 chk("fhz_stall", 64'(bus.stall), 64'(LU));
        tick();
        lc++;
        chk("fhz_cnt", 64'(bus.bubble_cnt), 64'(lc));
        chk("fhz_ctrl", 64'(bus.ex_ctrl), 64'd0);
        for (int i = 0; i < 17; i++) tick();
        chk("sat_cnt", 64'(bus.bubble_cnt), 64'(CMAX));
        bus.flush = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            bus.hold = ($urandom_range(0, 6) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            set_id(14'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom), $urandom);
            tick();
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
